legv8_multicycle_control: RTL
=============================

Name: legv8_multicycle_control

Overview:
- Multi-cycle main control FSM for the LEGv8 datapath. It sequences fetch, decode, execute, memory and writeback for the supported subset.
- Drives the ALUOp1/ALUOp2 pair consumed by the ALU control decoder, plus all register, memory and PC enables.
- Waits on a memory ready handshake, flags unsupported opcodes, and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opCodeField  in  11  instruction bits [31:21], taken from the IR.
- memReady  in  1  memory has completed the current read/write this cycle.
- pcWrite  out  1  unconditional PC load.
- pcWriteCond  out  1  PC load qualified by ALU zero (CBZ).
- iorD  out  1  memory address select: 0=PC, 1=ALUOut.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write request.
- irWrite  out  1  IR load.
- reg2Loc  out  1  register read port 2 select: 1=Rt field (STUR/CBZ).
- memToReg  out  1  writeback select: 1=MDR.
- regWrite  out  1  register file write.
- aluSrcA  out  1  0=PC, 1=regA.
- aluSrcB  out  2  00=regB, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- pcSource  out  2  00=ALU result, 01=ALUOut, 10=branch target from ALUOut.
- ALUOp1  out  1  ALU control opcode-field decode enable.
- ALUOp2  out  1  ALU control pass/compare select.
- illegalOp  out  1  sticky; set on an unsupported opcode.
- instrCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0): state=FETCH. instrCount=0, illegalOp=0. All decoded outputs take their FETCH values once rst_n rises.
- Outputs are a Moore decode of state. Unlisted outputs are 0 in every state.
- Opcode classes:
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ: top 8 bits 10110100.
  - B: top 6 bits 000101.
  - Any other code is illegal.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, ALUOp=00, pcSource=00.
  - irWrite and pcWrite assert only in the cycle memReady=1; next state DECODE.
  - memReady=0: hold FETCH with no IR/PC update.
- DECODE: aluSrcA=0, aluSrcB=11, ALUOp=00 (branch target into ALUOut). reg2Loc=1 for STUR/CBZ.
  - Next state: R-type→R_EXEC, LDUR/STUR→MEM_ADDR, CBZ→CBZ_EXEC, B→B_EXEC, illegal→HALT.
- R_EXEC: aluSrcA=1, aluSrcB=00, ALUOp1=1, ALUOp2=0 → R_WB.
- R_WB: regWrite=1, memToReg=0, increment instrCount → FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, ALUOp=00, reg2Loc held for STUR.
  - LDUR→MEM_READ, STUR→MEM_WRITE.
- MEM_READ: memRead=1, iorD=1. Hold until memReady, then → MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, increment instrCount → FETCH.
- MEM_WRITE: memWrite=1, iorD=1, reg2Loc=1. Hold until memReady; in that cycle increment instrCount → FETCH.
- CBZ_EXEC: aluSrcA=1, aluSrcB=00, reg2Loc=1, ALUOp1=0, ALUOp2=1 (pass B), pcWriteCond=1, pcSource=01. Increment instrCount → FETCH.
- B_EXEC: pcWrite=1, pcSource=10, increment instrCount → FETCH.
- HALT: illegalOp=1 is sticky and the state is terminal. Only rst_n leaves HALT.
- Opcode is sampled in DECODE, MEM_ADDR and MEM_* states. The IR is stable because irWrite=0 outside FETCH.
- instrCount wraps from all-ones to 0 with no flag.
- Reset mid-wait (e.g. in MEM_READ with memReady=0) returns to FETCH immediately. No partial regWrite occurs.
- memReady is ignored in states that do not request memory.

Decomposition:
- Shared package legv8_pkg holds:
  - state enum;
  - opcode constants OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ_PFX, OP_B_PFX;
  - ALUOp encodings ALUOP_ADD=00, ALUOP_RTYPE=10, ALUOP_PASSB=01;
  - aluSrcB/pcSource encodings.
- One natural sub-module: legv8_opclass_decode, combinational opcode→class (R/LD/ST/CBZ/B/ILLEGAL). It is reused by the bench scoreboard.

Test Plan:
- Reset then ADD (10001011000), memReady=1 always → states FETCH,DECODE,R_EXEC,R_WB. ALUOp1/2=1/0 in R_EXEC, regWrite in R_WB, instrCount=1 after 4 cycles.
- LDUR with memReady low 3 cycles in MEM_READ → memRead/iorD held 4 cycles. regWrite+memToReg in a single cycle afterwards. No extra instrCount increments.
- STUR then CBZ (opcode 10110100101) → memWrite asserted until memReady. In CBZ_EXEC: pcWriteCond=1, ALUOp1/2=0/1, reg2Loc=1. instrCount=2.
- B (00010100000) → pcWrite=1, pcSource=10 in B_EXEC, 3-cycle instruction.
- Opcode 11111111111 → HALT, illegalOp=1 persists 10 cycles with memReady toggling. rst_n low clears it and returns to FETCH.
- Preload 2^CNT_W−1 retirements (CNT_W=4 build, 16 ADDs) → instrCount wraps to 0. Async rst_n pulse mid-MEM_READ → FETCH with no regWrite.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle control path.
// Imported by the opcode-class decoder and the main control FSM.
package legv8_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_R_EXEC,
    ST_R_WB,
    ST_MEM_ADDR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_CBZ_EXEC,
    ST_B_EXEC,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LD,
    CLS_ST,
    CLS_CBZ,
    CLS_B,
    CLS_ILLEGAL
  } opclass_t;

  localparam logic [10:0] OP_ADD     = 11'b10001011000;
  localparam logic [10:0] OP_SUB     = 11'b11001011000;
  localparam logic [10:0] OP_AND     = 11'b10001010000;
  localparam logic [10:0] OP_ORR     = 11'b10101010000;
  localparam logic [10:0] OP_LDUR    = 11'b11111000010;
  localparam logic [10:0] OP_STUR    = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  // {ALUOp1, ALUOp2}
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;

  localparam logic [1:0] ALUSRCB_REG     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg2_loc;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

  // Instructions whose second source register comes from the Rt field.
  function automatic logic reads_rt(input opclass_t cls);
    return (cls == CLS_ST) || (cls == CLS_CBZ);
  endfunction

endpackage

// File: rtl/legv8_opclass_decode.sv
// Combinational classification of the IR opcode field into the
// instruction classes the control FSM sequences.
module legv8_opclass_decode
  import legv8_pkg::*;
(
  input  logic [10:0] op_code,
  output opclass_t    op_class
);

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    op_class = CLS_ILLEGAL;
    if (op_code[10:3] == OP_CBZ_PFX) begin
      op_class = CLS_CBZ;
    end else if (op_code[10:5] == OP_B_PFX) begin
      op_class = CLS_B;
    end else begin
      case (op_code)
        OP_ADD, OP_SUB, OP_AND, OP_ORR: op_class = CLS_R;
        OP_LDUR:                        op_class = CLS_LD;
        OP_STUR:                        op_class = CLS_ST;
        default:                        op_class = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle main control FSM for the LEGv8 datapath: sequences
// fetch/decode/execute/memory/writeback and counts retired instructions.
module legv8_multicycle_control
  import legv8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      opCodeField,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             reg2Loc,
  output logic             memToReg,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       pcSource,
  output logic             ALUOp1,
  output logic             ALUOp2,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instrCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t   state;
  opclass_t op_class;
  ctrl_t    ctrl;

  legv8_opclass_decode u_opclass (
    .op_code  (opCodeField),
    .op_class (op_class)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      illegalOp  <= 1'b0;
      instrCount <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (memReady) state <= ST_DECODE;
        end
        ST_DECODE: begin
          case (op_class)
            CLS_R:          state <= ST_R_EXEC;
            CLS_LD, CLS_ST: state <= ST_MEM_ADDR;
            CLS_CBZ:        state <= ST_CBZ_EXEC;
            CLS_B:          state <= ST_B_EXEC;
            default: begin
              state     <= ST_HALT;
              illegalOp <= 1'b1;
            end
          endcase
        end
        ST_R_EXEC: state <= ST_R_WB;
        ST_R_WB: begin
          state      <= ST_FETCH;
          instrCount <= instrCount + CNT_ONE;
        end
        ST_MEM_ADDR: begin
          state <= (op_class == CLS_ST) ? ST_MEM_WRITE : ST_MEM_READ;
        end
        ST_MEM_READ: begin
          if (memReady) state <= ST_MEM_WB;
        end
        ST_MEM_WB: begin
          state      <= ST_FETCH;
          instrCount <= instrCount + CNT_ONE;
        end
        ST_MEM_WRITE: begin
          if (memReady) begin
            state      <= ST_FETCH;
            instrCount <= instrCount + CNT_ONE;
          end
        end
        ST_CBZ_EXEC, ST_B_EXEC: begin
          state      <= ST_FETCH;
          instrCount <= instrCount + CNT_ONE;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Moore decode; only the memory-handshake strobes look at memReady.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = memReady;
        ctrl.pc_write  = memReady;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.reg2_loc  = reads_rt(op_class);
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_REG;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.reg2_loc  = (op_class == CLS_ST);
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
        ctrl.reg2_loc  = 1'b1;
      end
      ST_CBZ_EXEC: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_REG;
        ctrl.reg2_loc      = 1'b1;
        ctrl.alu_op        = ALUOP_PASSB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_B_EXEC: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_BRANCH;
      end
      default: ctrl = '0;
    endcase
  end

  assign pcWrite     = ctrl.pc_write;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign iorD        = ctrl.ior_d;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign irWrite     = ctrl.ir_write;
  assign reg2Loc     = ctrl.reg2_loc;
  assign memToReg    = ctrl.mem_to_reg;
  assign regWrite    = ctrl.reg_write;
  assign aluSrcA     = ctrl.alu_src_a;
  assign aluSrcB     = ctrl.alu_src_b;
  assign pcSource    = ctrl.pc_source;
  assign ALUOp1      = ctrl.alu_op[1];
  assign ALUOp2      = ctrl.alu_op[0];

endmodule
